axis2adi_conv: RTL and testbench
================================

# axis2adi_conv

Transmit-direction converter: accepts a length-programmed AXI-Stream burst from a DMA and hands it, one beat per `dac_valid` strobe, to an ADI-style DAC FIFO interface. It is the counterpart to the receive-path ADI-to-AXIS converter. It sits between the DMA MM2S stream and the DAC core's data-request port, with control and status exchanged as 32-bit words with the block's AXI-Lite register interface.

## Interface
- `C_S_AXIS_TDATA_NUM_BYTES`, 8: bytes per stream beat and per DAC sample word.
- `C_FIFO_DEPTH_LOG2`, 4: log2 of the internal buffer depth in beats (16).
- `AXIS_ACLK`  in  1: the block's single clock; every register is clocked on its rising edge.
- `AXIS_ARESETN`  in  1: synchronous reset, active low.
- `S_AXIS_TDATA`  in  8*NB: stream data.
- `S_AXIS_TSTRB`  in  NB: accepted but ignored; every beat is treated as full width.
- `S_AXIS_TLAST`  in  1: end-of-burst marker.
- `S_AXIS_TVALID`  in  1: stream valid.
- `S_AXIS_TREADY`  out  1: stream ready.
- `dac_valid`  in  1: DAC requests one sample word on this cycle.
- `dac_data`  out  8*NB: sample word delivered to the DAC.
- `dac_dunf`  out  1: one-cycle pulse when a request is served while the buffer is empty.
- `ctrl`  in  32: bit0 = enable, bit1 = clear status (level-sensitive); bits 31:2 are reserved.
- `num_bytes`  in  32: burst length in bytes.
- `stat`  out  32: bit0 = busy, bit1 = done, bit2 = underflow (sticky), bit3 = TLAST error (sticky), bits 15:8 = FIFO fill level; other bits read 0.

## Operation
- Beat count `total = num_bytes >> log2(NB)`. The low bits of `num_bytes` are ignored. `total` is sampled once, on the IDLE→RUN transition.
- **IDLE.** `S_AXIS_TREADY` = 0 and the FIFO is empty.
  - Enable = 1 with `total` ≠ 0: go to RUN.
  - Enable = 1 with `total` = 0: go directly to DONE.
- **RUN.**
  - `S_AXIS_TREADY` = !full && (`beats_in` < `total`).
  - A beat is accepted when TVALID and TREADY are both high; it is pushed to the FIFO and `beats_in` increments.
  - On every `dac_valid`:
    - FIFO non-empty: pop the FIFO into `dac_data` and increment `beats_out`.
    - FIFO empty: load `dac_data` with 0, pulse `dac_dunf`, set `stat`[2]; `beats_out` does not advance.
  - When the pop that brings `beats_out` to `total` completes, go to DONE.
- **DONE.** `S_AXIS_TREADY` = 0. A `dac_valid` in this state loads `dac_data` with 0 and raises no underflow. Enable = 0 returns the block to IDLE.
- **Abort.** Enable = 0 while in RUN returns the block to IDLE on the next edge. This flushes the FIFO, clears both counters and drives `S_AXIS_TREADY` low. `done` is not set.
- **TLAST check.** `stat`[3] is set if either:
  - TLAST = 1 on an accepted beat other than beat `total`-1, or
  - TLAST = 0 on beat `total`-1.

  The transfer always continues to `total` beats regardless of TLAST.
- `busy` = (state == RUN); `done` = (state == DONE).
- `ctrl`[1] clears bits 2 and 3. If a clear and a set occur in the same cycle, the set wins.
- Simultaneous push and pop on the same edge are both performed and the fill level is unchanged. With depth 2^N, the fill counter is N+1 bits wide, and the read and write pointers wrap modulo 2^N.

## Timing
- Reset values: `S_AXIS_TREADY` 0, `dac_data` 0, `dac_dunf` 0, `stat` 0, state IDLE, FIFO empty.
- Reset asserted mid-burst returns the block to these values on that edge.
- IDLE→RUN takes one edge after enable is sampled high. `S_AXIS_TREADY` can first be 1 in the following cycle.
- `S_AXIS_TREADY` is decoded from registered state, counters and fill level only. It has no combinational path from TVALID or `dac_valid`.
- A beat accepted at edge N is poppable by a `dac_valid` sampled at edge N+1.
- `dac_data` and `dac_dunf` are registered and update on the edge at which `dac_valid` is sampled. `dac_data` holds its value between requests.
- `done` rises on the edge of the final pop.

## Structure
- Shared package `axis2adi_pkg`:
  - state encoding (IDLE = 0, RUN = 1, DONE = 2),
  - `ctrl`/`stat` bit-index constants,
  - function computing log2(NB).
- Sub-module `axis2adi_fifo`: synchronous FIFO with a registered read port, outputs `full`, `empty` and `level`, and a synchronous `flush` input.
- The top level holds the FSM, the beat counters, the TLAST checker and the status logic.

## Test plan
- **Nominal burst.** NB = 8, `num_bytes` = 64, enable; 8 beats with TLAST on beat 7; `dac_valid` every cycle → 8 words out in order, `done` = 1, `stat`[3:2] = 0.
- **Back-pressure.** `dac_valid` held low while 20 beats are offered → TREADY drops after 16 accepted and level = 16; `dac_valid` then asserted → all 20 words delivered with no loss.
- **Underflow.** `num_bytes` = 32, TVALID delayed 5 cycles after enable with `dac_valid` high → 5 zero words, 5 `dac_dunf` pulses, `stat`[2] = 1; the 4 real words still follow before `done`.
- **TLAST error.** TLAST on beat 1 of a 4-beat burst → `stat`[3] = 1 and 4 beats are still transferred. `ctrl`[1] afterwards → `stat`[3] = 0.
- **Zero length.** `num_bytes` = 7 → IDLE→DONE in one edge, TREADY never high.
- **Abort and reset.** Enable dropped after 3 of 8 beats → IDLE, level = 0, `done` = 0. A reset pulse in the middle of a second burst → all outputs return to 0.

Source files
------------

// File: rtl/axis2adi_pkg.sv
// Shared types and constants for the AXIS-to-ADI DAC converter.
package axis2adi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_CLR   = 1;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_DUNF  = 2;
  localparam int unsigned STAT_TLAST = 3;
  localparam int unsigned STAT_LVL   = 8;
  localparam int unsigned STAT_LVL_W = 8;

  // Smallest r with 2**r >= nb; used as the byte-to-beat shift.
  function automatic int unsigned nb_log2(input int unsigned nb);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < nb) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis2adi_fifo.sv
// Synchronous FIFO with registered read data, fill level and flush.
module axis2adi_fifo #(
  parameter int unsigned W  = 64,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          rd_clr,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointers and fill level; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

  // Registered read port; rd_clr loads zero when no word is popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (do_rd) begin
      rd_data <= mem[rptr];
    end else if (rd_clr) begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/axis2adi_conv.sv
// Transmit converter: length-programmed AXI-Stream burst to ADI DAC FIFO port.
module axis2adi_conv
  import axis2adi_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_NUM_BYTES = 8,
  parameter int unsigned C_FIFO_DEPTH_LOG2        = 4
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
  input  logic                                  S_AXIS_TLAST,
  input  logic                                  S_AXIS_TVALID,
  output logic                                  S_AXIS_TREADY,
  input  logic                                  dac_valid,
  output logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] dac_data,
  output logic                                  dac_dunf,
  input  logic [31:0]                           ctrl,
  input  logic [31:0]                           num_bytes,
  output logic [31:0]                           stat
);

  localparam int unsigned DW      = 8 * C_S_AXIS_TDATA_NUM_BYTES;
  localparam int unsigned NB_LOG2 = nb_log2(C_S_AXIS_TDATA_NUM_BYTES);
  localparam int unsigned LW      = C_FIFO_DEPTH_LOG2 + 1;

  state_t        state;
  state_t        state_next;
  logic [31:0]   total;
  logic [31:0]   total_q;
  logic [31:0]   beats_in;
  logic [31:0]   beats_out;
  logic          en;
  logic          clr;
  logic          ready;
  logic          push;
  logic          pop;
  logic          zero_rd;
  logic          flush;
  logic          dunf_set;
  logic          tlast_set;
  logic          dunf_sticky;
  logic          tlast_sticky;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          unused_bits;

  assign total         = num_bytes >> NB_LOG2;
  assign en            = ctrl[CTRL_EN];
  assign clr           = ctrl[CTRL_CLR];
  assign S_AXIS_TREADY = ready;
  assign unused_bits   = ^{S_AXIS_TSTRB, ctrl[31:2]};

  axis2adi_fifo #(
    .W  (DW),
    .AW (C_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (S_AXIS_TDATA),
    .rd_en   (pop),
    .rd_clr  (zero_rd),
    .rd_data (dac_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // State register.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) state <= ST_IDLE;
    else               state <= state_next;
  end

  // Next state, handshake, FIFO control and TLAST check.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    zero_rd    = 1'b0;
    flush      = 1'b0;
    dunf_set   = 1'b0;
    tlast_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_next = (total == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        ready = !full && (beats_in < total_q);
        if (!en) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else begin
          push = S_AXIS_TVALID && ready;
          if (dac_valid) begin
            if (!empty) begin
              pop = 1'b1;
              if (beats_out + 32'd1 == total_q) state_next = ST_DONE;
            end else begin
              zero_rd  = 1'b1;
              dunf_set = 1'b1;
            end
          end
          if (push) begin
            tlast_set = (beats_in == total_q - 32'd1) ? !S_AXIS_TLAST : S_AXIS_TLAST;
          end
        end
      end
      ST_DONE: begin
        zero_rd = dac_valid;
        if (!en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Burst length capture, beat counters, underflow pulse and sticky status.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      total_q      <= '0;
      beats_in     <= '0;
      beats_out    <= '0;
      dac_dunf     <= 1'b0;
      dunf_sticky  <= 1'b0;
      tlast_sticky <= 1'b0;
    end else begin
      if (state == ST_IDLE) total_q <= total;
      if (state_next != ST_RUN) begin
        beats_in  <= '0;
        beats_out <= '0;
      end else begin
        if (push) beats_in  <= beats_in + 32'd1;
        if (pop)  beats_out <= beats_out + 32'd1;
      end
      dac_dunf     <= dunf_set;
      dunf_sticky  <= dunf_set  ? 1'b1 : (clr ? 1'b0 : dunf_sticky);
      tlast_sticky <= tlast_set ? 1'b1 : (clr ? 1'b0 : tlast_sticky);
    end
  end

  // Status word assembled from registered state.
  always_comb begin
    stat                          = '0;
    stat[STAT_BUSY]               = (state == ST_RUN);
    stat[STAT_DONE]               = (state == ST_DONE);
    stat[STAT_DUNF]               = dunf_sticky;
    stat[STAT_TLAST]              = tlast_sticky;
    stat[STAT_LVL +: STAT_LVL_W]  = STAT_LVL_W'(level);
  end

endmodule

// File: tb/tb_axis2adi_conv.sv
// Directed self-checking bench for axis2adi_conv.
module tb_axis2adi_conv;

  localparam int unsigned NB = 8;
  localparam int unsigned DW = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tdata;
  logic [NB-1:0] tstrb;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          dac_valid;
  logic [DW-1:0] dac_data;
  logic          dac_dunf;
  logic [31:0]   ctrl;
  logic [31:0]   num_bytes;
  logic [31:0]   stat;

  int vectors     = 0;
  int miscompares = 0;
  int tid         = 0;
  int nu          = 0;

  axis2adi_conv #(
    .C_S_AXIS_TDATA_NUM_BYTES (NB),
    .C_FIFO_DEPTH_LOG2        (4)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .dac_valid     (dac_valid),
    .dac_data      (dac_data),
    .dac_dunf      (dac_dunf),
    .ctrl          (ctrl),
    .num_bytes     (num_bytes),
    .stat          (stat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int t, input int i);
    return {16'hDA00 | 16'(t), 16'h0000, 32'(i + 1)};
  endfunction

  task automatic start(input int nbytes);
    num_bytes = 32'(nbytes);
    ctrl      = 32'h1;
    tick;
  endtask

  // Drives a burst and checks every cycle against a small FIFO model.
  task automatic xfer(input string tag, input int total, input int vdelay, input int dv_start,
                      input int tlast_beat, input int cycles, input bit expect_done,
                      output int n_unf);
    logic [63:0] q[$];
    int sent   = 0;
    int popped = 0;
    int lvl    = 0;
    bit acc, do_pop, unf;
    n_unf = 0;
    for (int c = 0; c < cycles && popped < total; c++) begin
      tvalid    = (c >= vdelay) && (sent < total);
      tdata     = word(tid, sent);
      tlast     = (sent == tlast_beat);
      dac_valid = (c >= dv_start);
      check({tag, "_tready"}, 64'(tready), 64'((lvl < 16) && (sent < total)));
      acc    = tvalid && tready;
      do_pop = dac_valid && (lvl > 0);
      unf    = dac_valid && (lvl == 0);
      tick;
      if (acc) begin
        q.push_back(word(tid, sent));
        sent++;
      end
      lvl = lvl + int'(acc) - int'(do_pop);
      if (do_pop) begin
        popped++;
        check({tag, "_data"}, dac_data, q.pop_front());
      end
      if (unf) begin
        n_unf++;
        check({tag, "_zero"}, dac_data, 64'h0);
      end
      check({tag, "_dunf"}, 64'(dac_dunf), 64'(unf));
      check({tag, "_level"}, 64'(stat[15:8]), 64'(lvl));
    end
    tvalid    = 1'b0;
    tlast     = 1'b0;
    dac_valid = 1'b0;
    if (expect_done) begin
      check({tag, "_count"}, 64'(popped), 64'(total));
      check({tag, "_done"}, 64'(stat[1:0]), 64'h2);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tdata     = '0;
    tstrb     = '1;
    tlast     = 1'b0;
    tvalid    = 1'b0;
    dac_valid = 1'b0;
    ctrl      = 32'h0;
    num_bytes = 32'h0;
    tick;
    tick;
    check("rst_stat", 64'(stat), 64'h0);
    check("rst_tready", 64'(tready), 64'h0);
    check("rst_data", dac_data, 64'h0);
    check("rst_dunf", 64'(dac_dunf), 64'h0);
    rst_n = 1'b1;
    tick;

    // Nominal 8-beat burst, dac_valid every cycle from the first beat on.
    tid = 1;
    start(64);
    check("nom_busy", 64'(stat), 64'h1);
    xfer("nom", 8, 0, 1, 7, 40, 1'b1, nu);
    check("nom_nunf", 64'(nu), 64'h0);
    check("nom_err", 64'(stat[3:2]), 64'h0);
    dac_valid = 1'b1;
    tick;
    check("done_zero", dac_data, 64'h0);
    check("done_nodunf", 64'(dac_dunf), 64'h0);
    dac_valid = 1'b0;
    ctrl = 32'h0;
    tick;
    check("nom_idle", 64'(stat), 64'h0);

    // Back-pressure: 20 beats with DAC idle for the first 30 cycles.
    tid = 2;
    start(160);
    xfer("bp", 20, 0, 30, 19, 100, 1'b1, nu);
    check("bp_nunf", 64'(nu), 64'h0);
    check("bp_err", 64'(stat[3:2]), 64'h0);
    ctrl = 32'h0;
    tick;

    // Underflow: stream starts late while DAC requests every cycle.
    tid = 3;
    start(32);
    xfer("unf", 4, 4, 0, 3, 40, 1'b1, nu);
    check("unf_n", 64'(nu), 64'd5);
    check("unf_sticky", 64'(stat[2]), 64'h1);
    ctrl = 32'h2;
    tick;
    check("unf_clr", 64'(stat), 64'h0);

    // TLAST on beat 1 of 4; all beats still flow, then clear.
    tid = 4;
    start(32);
    xfer("tl", 4, 0, 1, 1, 40, 1'b1, nu);
    check("tl_err", 64'(stat[3:2]), 64'h2);
    ctrl = 32'h3;
    tick;
    check("tl_clr", 64'(stat), 64'h2);
    ctrl = 32'h0;
    tick;

    // Zero length: 7 bytes rounds down to no beats.
    check("zl_tready0", 64'(tready), 64'h0);
    start(7);
    check("zl_stat", 64'(stat), 64'h2);
    check("zl_tready1", 64'(tready), 64'h0);
    ctrl = 32'h0;
    tick;
    check("zl_idle", 64'(stat), 64'h0);

    // Abort after 3 of 8 beats with the DAC idle.
    tid = 5;
    start(64);
    xfer("ab", 8, 0, 100, 7, 3, 1'b0, nu);
    check("ab_lvl3", 64'(stat[15:8]), 64'd3);
    ctrl = 32'h0;
    tick;
    check("ab_stat", 64'(stat), 64'h0);
    check("ab_tready", 64'(tready), 64'h0);

    // Reset pulse in the middle of a burst.
    tid = 6;
    start(64);
    xfer("rs", 8, 0, 1, 7, 4, 1'b0, nu);
    check("rs_pre", dac_data, word(6, 2));
    rst_n = 1'b0;
    tick;
    check("rs_data", dac_data, 64'h0);
    check("rs_dunf", 64'(dac_dunf), 64'h0);
    check("rs_stat", 64'(stat), 64'h0);
    check("rs_tready", 64'(tready), 64'h0);
    rst_n = 1'b1;
    ctrl  = 32'h0;
    tick;
    check("rs_after", 64'(stat), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
